// File: rtl/system_regfile_wb_pkg.sv
// Shared types and defaults for the writeback register file.
// Holds the ALU result layout and the pending-writeback record.
package system_regfile_wb_pkg;

    localparam int NREGS_DEF      = 8;
    localparam int AW_DEF         = 3;
    localparam int FIFO_DEPTH_DEF = 2;

    localparam int DW    = 16;
    localparam int RES_W = DW + 1;
    localparam int RD_W  = 8;

    // ALU word: [16:1] signed result, [0] condition bit.
    localparam int RES_HI = 16;
    localparam int RES_LO = 1;
    localparam int COND_B = 0;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic [RD_W-1:0]  rd;
        logic             wen;
        logic             fen;
    } wb_entry_t;

    function automatic logic [DW-1:0] res_value(input logic [RES_W-1:0] r);
        return r[RES_HI:RES_LO];
    endfunction

    function automatic logic res_cond(input logic [RES_W-1:0] r);
        return r[COND_B];
    endfunction

endpackage

// File: rtl/system_regfile_wb_if.sv
// ALU request, load return and operand read bundle.
// The core side drives requests; the regfile answers.
interface system_regfile_wb_if
    import system_regfile_wb_pkg::*;
#(
    parameter int AW = AW_DEF
) ();
    logic                 alu_valid;
    logic                 alu_ready;
    logic [RES_W-1:0]     alu_res;
    logic [AW-1:0]        alu_rd;
    logic                 alu_wen;
    logic                 alu_fen;
    logic                 ld_valid;
    logic [AW-1:0]        ld_rd;
    logic [DW-1:0]        ld_data;
    logic [AW-1:0]        ra_addr;
    logic [AW-1:0]        rb_addr;
    logic signed [DW-1:0] ra_data;
    logic signed [DW-1:0] rb_data;
    logic                 ra_busy;
    logic                 rb_busy;
    logic                 flag;

    modport master (
        output alu_valid, alu_res, alu_rd, alu_wen, alu_fen,
        output ld_valid, ld_rd, ld_data, ra_addr, rb_addr,
        input  alu_ready, ra_data, rb_data, ra_busy, rb_busy, flag
    );

    modport slave (
        input  alu_valid, alu_res, alu_rd, alu_wen, alu_fen,
        input  ld_valid, ld_rd, ld_data, ra_addr, rb_addr,
        output alu_ready, ra_data, rb_data, ra_busy, rb_busy, flag
    );
endinterface

// File: rtl/system_wb_fifo.sv
// Pending ALU writeback queue with per-slot rd compare.
// Slots are tracked with live bits so busy lookups stay flat.
module system_wb_fifo
    import system_regfile_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       entry_in,
    input  logic            pop,
    output wb_entry_t       head,
    output logic [CW-1:0]   count,
    input  logic [RD_W-1:0] cmp_a,
    input  logic [RD_W-1:0] cmp_b,
    output logic            hit_a,
    output logic            hit_b
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        slots [DEPTH];
    logic [DEPTH-1:0] live;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head = slots[rd_ptr];

    // Pointer, occupancy and live-slot bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else begin
            if (pop) begin
                rd_ptr       <= bump(rd_ptr);
                live[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr       <= bump(wr_ptr);
                live[wr_ptr] <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry payload storage; no reset needed, live bits guard it.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= entry_in;
        end
    end

    // A slot retiring this cycle no longer counts as pending.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && slots[i].wen &&
                !(pop && (PW'(i) == rd_ptr))) begin
                if (slots[i].rd == cmp_a) hit_a = 1'b1;
                if (slots[i].rd == cmp_b) hit_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/system_regfile_wb.sv
// Register file with one write port shared by loads and ALU retires.
// Loads win the port; ALU results wait in a small in-order queue.
module system_regfile_wb
    import system_regfile_wb_pkg::*;
#(
    parameter int NREGS      = NREGS_DEF,
    parameter int AW         = AW_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    system_regfile_wb_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wb_entry_t      push_entry;
    wb_entry_t      head;
    logic [CW-1:0]  count;
    logic           ready;
    logic           empty;
    logic           push;
    logic           pop;
    logic           hit_a;
    logic           hit_b;

    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;

    logic [DW-1:0]  regs [NREGS];
    logic           flag_q;

    assign ready = (count < CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = bus.alu_valid && ready;
    assign pop   = !bus.ld_valid && !empty;

    assign push_entry = '{
        res: bus.alu_res,
        rd:  RD_W'(bus.alu_rd),
        wen: bus.alu_wen,
        fen: bus.alu_fen
    };

    system_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (system1000),
        .rst      (system1000_rst),
        .push     (push),
        .entry_in (push_entry),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .cmp_a    (RD_W'(bus.ra_addr)),
        .cmp_b    (RD_W'(bus.rb_addr)),
        .hit_a    (hit_a),
        .hit_b    (hit_b)
    );

    // Single write port: load return first, otherwise queue head.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (bus.ld_valid) begin
            wr_en   = 1'b1;
            wr_addr = bus.ld_rd;
            wr_data = bus.ld_data;
        end else if (pop) begin
            wr_en   = head.wen;
            wr_addr = AW'(head.rd);
            wr_data = res_value(head.res);
        end
    end

    // Register array; r0 is never written.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Condition flag follows retiring entries with fen set.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            flag_q <= 1'b0;
        end else if (pop && head.fen) begin
            flag_q <= res_cond(head.res);
        end
    end

    // Operand reads with same-cycle write bypass.
    always_comb begin
        bus.ra_data = regs[bus.ra_addr];
        bus.rb_data = regs[bus.rb_addr];
        if (wr_en && (wr_addr == bus.ra_addr)) bus.ra_data = wr_data;
        if (wr_en && (wr_addr == bus.rb_addr)) bus.rb_data = wr_data;
        if (bus.ra_addr == '0) bus.ra_data = '0;
        if (bus.rb_addr == '0) bus.rb_data = '0;
    end

    assign bus.ra_busy   = hit_a && (bus.ra_addr != '0);
    assign bus.rb_busy   = hit_b && (bus.rb_addr != '0);
    assign bus.alu_ready = ready;
    assign bus.flag      = flag_q;

endmodule

// File: tb/tb_system_regfile_wb.sv
// Bench for system_regfile_wb: directed scenarios with literal
// expectations, then random traffic against a queue-based model.
module tb_system_regfile_wb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    system_regfile_wb_if #(.AW(3)) bus ();

    system_regfile_wb u_dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    typedef struct {
        logic [16:0] res;
        logic [2:0]  rd;
        logic        wen;
        logic        fen;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mregs [8];
    logic        mflag;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Model view of this cycle's write port.
    task automatic port(output logic we, output logic [2:0] wa,
                        output logic [15:0] wd, output logic ret);
        we = 0; wa = 0; wd = 0; ret = 0;
        if (bus.ld_valid) begin
            we = 1; wa = bus.ld_rd; wd = bus.ld_data;
        end else if (mq.size() > 0) begin
            ret = 1;
            we = mq[0].wen; wa = mq[0].rd; wd = mq[0].res[16:1];
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] a,
        input logic we, input logic [2:0] wa, input logic [15:0] wd);
        if (a == 0) return 16'h0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a,
                                      input logic ret);
        if (a == 0) return 1'b0;
        for (int j = (ret ? 1 : 0); j < mq.size(); j++)
            if (mq[j].wen && mq[j].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_model();
        logic we, ret;
        logic [2:0] wa;
        logic [15:0] wd;
        port(we, wa, wd, ret);
        chk("ready", 16'(bus.alu_ready), 16'(mq.size() < 2));
        chk("ra_data", bus.ra_data, exp_rd(bus.ra_addr, we, wa, wd));
        chk("rb_data", bus.rb_data, exp_rd(bus.rb_addr, we, wa, wd));
        chk("ra_busy", 16'(bus.ra_busy), 16'(exp_busy(bus.ra_addr, ret)));
        chk("rb_busy", 16'(bus.rb_busy), 16'(exp_busy(bus.rb_addr, ret)));
        chk("flag", 16'(bus.flag), 16'(mflag));
    endtask

    task automatic update_model();
        ent_t e;
        bit acc;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 8; i++) mregs[i] = 0;
            mflag = 0;
            return;
        end
        acc = bus.alu_valid && (mq.size() < 2);
        if (bus.ld_valid) begin
            if (bus.ld_rd != 0) mregs[bus.ld_rd] = bus.ld_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.wen && e.rd != 0) mregs[e.rd] = e.res[16:1];
            if (e.fen) mflag = e.res[0];
        end
        if (acc) begin
            e.res = bus.alu_res; e.rd = bus.alu_rd;
            e.wen = bus.alu_wen; e.fen = bus.alu_fen;
            mq.push_back(e);
        end
    endtask

    // Called 1 time unit after negedge with inputs settled.
    task automatic tick();
        if (!rst) check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_res = 0; bus.alu_rd = 0;
        bus.alu_wen = 0; bus.alu_fen = 0;
        bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0;
    endtask

    task automatic alu(input logic [15:0] val, input logic c,
        input logic [2:0] rd, input logic w, input logic f);
        bus.alu_valid = 1; bus.alu_res = {val, c};
        bus.alu_rd = rd; bus.alu_wen = w; bus.alu_fen = f;
    endtask

    task automatic ld(input logic v, input logic [2:0] rd,
                      input logic [15:0] d);
        bus.ld_valid = v; bus.ld_rd = rd; bus.ld_data = d;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        idle();
        bus.ra_addr = 0; bus.rb_addr = 0;
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        mflag = 0;
        rst = 1;
        @(negedge clk); settle();
        tick(); tick();
        rst = 0; settle();

        // Reset state.
        chk("rst_ready", 16'(bus.alu_ready), 16'd1);
        chk("rst_flag", 16'(bus.flag), 16'd0);
        bus.ra_addr = 3; bus.rb_addr = 7; settle();
        chk("rst_ra", bus.ra_data, 16'd0);
        chk("rst_busy", 16'(bus.ra_busy), 16'd0);

        // Basic writeback to r3 with flag.
        alu(16'd5, 1'b1, 3'd3, 1, 1); settle();
        tick();
        idle(); settle();
        chk("wb_bypass", bus.ra_data, 16'd5);
        tick();
        chk("wb_r3", bus.ra_data, 16'd5);
        chk("wb_flag", 16'(bus.flag), 16'd1);

        // Loads hold the port while two ALU requests queue up.
        bus.ra_addr = 1; bus.rb_addr = 2;
        ld(1, 3'd5, 16'h1111); alu(16'd10, 1'b0, 3'd1, 1, 0); settle();
        chk("lp_rdy0", 16'(bus.alu_ready), 16'd1);
        tick();
        ld(1, 3'd6, 16'h2222); alu(16'd20, 1'b0, 3'd2, 1, 0); settle();
        chk("lp_rdy1", 16'(bus.alu_ready), 16'd1);
        tick();
        idle(); ld(1, 3'd7, 16'h3333); settle();
        chk("lp_full", 16'(bus.alu_ready), 16'd0);
        chk("lp_busy_a", 16'(bus.ra_busy), 16'd1);
        chk("lp_nowr", bus.ra_data, 16'd0);
        tick();
        idle(); settle();
        chk("lp_ret1", bus.ra_data, 16'd10);
        chk("lp_busy_b", 16'(bus.rb_busy), 16'd1);
        tick();
        chk("lp_ret2", bus.rb_data, 16'd20);
        chk("lp_r1", bus.ra_data, 16'd10);
        tick();
        chk("lp_r2", bus.rb_data, 16'd20);

        // Load overtakes a pending ALU write to r2.
        alu(16'hFFF9, 1'b0, 3'd2, 1, 0); settle();
        tick();
        idle(); ld(1, 3'd2, 16'd9); settle();
        chk("wo_ld", bus.rb_data, 16'd9);
        chk("wo_busy", 16'(bus.rb_busy), 16'd1);
        tick();
        idle(); settle();
        chk("wo_ret", bus.rb_data, 16'hFFF9);
        chk("wo_nobusy", 16'(bus.rb_busy), 16'd0);
        tick();
        chk("wo_final", bus.rb_data, 16'hFFF9);

        // r0 discards data but flag still updates.
        bus.ra_addr = 0;
        alu(16'd100, 1'b0, 3'd0, 1, 1); settle();
        tick();
        idle(); settle();
        chk("r0_busy", 16'(bus.ra_busy), 16'd0);
        chk("r0_data", bus.ra_data, 16'd0);
        tick();
        chk("r0_flag", 16'(bus.flag), 16'd0);
        chk("r0_after", bus.ra_data, 16'd0);

        // Bypass of a max-positive retire.
        alu(16'h7FFF, 1'b0, 3'd4, 1, 0); settle();
        tick();
        idle(); bus.ra_addr = 4; settle();
        chk("byp", bus.ra_data, 16'h7FFF);
        tick();

        // Reset with two entries pending.
        ld(1, 3'd1, 16'h0042); alu(16'd3, 1'b1, 3'd5, 1, 1); settle();
        tick();
        ld(1, 3'd1, 16'h0043); alu(16'd4, 1'b1, 3'd6, 1, 1); settle();
        tick();
        idle(); ld(1, 3'd2, 16'h5555); rst = 1; settle();
        tick();
        rst = 0; idle(); settle();
        chk("mr_ready", 16'(bus.alu_ready), 16'd1);
        chk("mr_flag", 16'(bus.flag), 16'd0);
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 8; a++) begin
                bus.ra_addr = 3'(a); bus.rb_addr = 3'(7 - a); settle();
                chk("mr_reg", bus.ra_data, 16'd0);
                chk("mr_busy", 16'(bus.rb_busy), 16'd0);
            end
            tick();
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            bus.alu_valid = ($urandom_range(0, 2) != 0);
            bus.alu_res = 17'($urandom);
            bus.alu_rd = 3'($urandom);
            bus.alu_wen = ($urandom_range(0, 3) != 0);
            bus.alu_fen = 1'($urandom);
            bus.ld_valid = ($urandom_range(0, 2) == 0);
            bus.ld_rd = 3'($urandom);
            bus.ld_data = 16'($urandom);
            bus.ra_addr = 3'($urandom);
            bus.rb_addr = 3'($urandom);
            settle();
            tick();
        end
        rst = 0; idle(); settle();
        for (int n = 0; n < 4; n++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/system_regfile_wb.md
SYSTEM_REGFILE_WB -- requirements
Module: system_regfile_wb

Interface
REQ-001 Parameters SHALL be: NREGS, 8, number of 16-bit registers; AW, 3, register address width; FIFO_DEPTH, 2, pending-ALU-writeback entries.
REQ-002 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-003 system1000  in  1  clock; all state updates on its rising edge.
REQ-004 system1000_rst  in  1  synchronous active-high reset.
REQ-005 alu_valid  in  1  ALU-result writeback request.
REQ-006 alu_ready  out  1  writeback FIFO can accept a request.
REQ-007 alu_res  in  17  ALU output word: [16:1] signed result, [0] condition bit.
REQ-008 alu_rd  in  AW  destination register.
REQ-009 alu_wen  in  1  write result to alu_rd.
REQ-010 alu_fen  in  1  write condition bit to flag register.
REQ-011 ld_valid  in  1  memory load-return write, with priority and no backpressure.
REQ-012 ld_rd  in  AW  load destination register.
REQ-013 ld_data  in  16  load data.
REQ-014 ra_addr, rb_addr  in  AW each  read addresses.
REQ-015 ra_data, rb_data  out  16 each  signed read data for the ALU operands.
REQ-016 ra_busy, rb_busy  out  1 each  addressed register has a pending FIFO write.
REQ-017 flag  out  1  committed condition flag.

Function
REQ-018 Handshake: an ALU request SHALL be accepted in a cycle when alu_valid and alu_ready are both 1.
REQ-019 Request data: an accepted request SHALL push {alu_res, alu_rd, alu_wen, alu_fen} into the FIFO.
REQ-020 Ready: alu_ready SHALL equal (FIFO count < FIFO_DEPTH), registered state only, with no combinational path from alu_valid.
REQ-021 Write port: the register file SHALL have one write port per cycle.
REQ-022 Load priority: when ld_valid=1, the port SHALL write ld_data to ld_rd and the FIFO head SHALL NOT retire that cycle.
REQ-023 Retire: when ld_valid=0 and the FIFO is non-empty, the head SHALL retire.
REQ-024 Retire write: on retire, alu_res[16:1] SHALL be written to rd if wen=1.
REQ-025 Retire flag: on retire, flag SHALL take alu_res[0] if fen=1; the flag update SHALL be independent of wen.
REQ-026 Pop: the FIFO SHALL pop the retired head.
REQ-027 Simultaneous push/pop: a push and a retire in the same cycle on a full FIFO SHALL NOT be permitted (ready=0); on a non-full FIFO the count SHALL be unchanged.
REQ-028 Empty FIFO: with an empty FIFO, an accepted request SHALL NOT retire in its accept cycle; minimum accept-to-write latency SHALL be 1 cycle.
REQ-029 Pointers: FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 Register 0: register 0 SHALL read 0 at all times; writes to it SHALL be discarded (a retire still pops and still updates flag).
REQ-031 Reads: reads SHALL be combinational from the register array, with same-cycle write bypass: if the write port targets a non-zero address equal to ra_addr/rb_addr, the read data SHALL be the data being written.
REQ-032 Busy flags: ra_busy/rb_busy SHALL be 1 iff a non-zero address matches any valid FIFO entry with wen=1 that does not retire this cycle.
REQ-033 Write ordering: load writes overtaking FIFO entries to the same rd SHALL be overwritten later by the FIFO retire, in program order.

Reset
REQ-034 Reset effect: on system1000_rst=1 at a clock edge, all registers, flag, FIFO pointers and count SHALL become 0, so alu_ready=1 and busy=0 in the next cycle.
REQ-035 Inputs during reset: inputs SHALL be ignored in reset cycles; pending FIFO entries SHALL be discarded, not retired.

Structure
REQ-036 Shared package: the package SHALL hold the NREGS/AW/FIFO_DEPTH defaults, the 17-bit ALU result layout (result field [16:1], condition bit [0]) and the FIFO entry record {res, rd, wen, fen}.
REQ-037 Sub-module: one sub-module, system_wb_fifo, SHALL implement the FIFO (push, pop, count, entry-compare outputs); the register array, arbitration and bypass SHALL stay in system_regfile_wb.

Verification
REQ-038 Basic writeback: accept alu_res={16'sd5,1} rd=3 wen=1 fen=1 on an idle bus -> next cycle r3=5 and flag=1; ra_addr=3 reads 5.
REQ-039 Load priority: keep ld_valid=1 three cycles while two ALU requests arrive -> alu_ready=0 after the second accept, no ALU retire until ld_valid=0, then both retire in order on consecutive cycles.
REQ-040 Write ordering: ALU request rd=2 value -7 pending while ld writes rd=2 value 9 -> r2 reads 9, rb_busy=1, then r2=-7 (16'hFFF9) after retire.
REQ-041 Register 0: accept rd=0 wen=1 fen=1 alu_res={16'sd100,0} -> r0 reads 0, flag=0, ra_busy=0 for address 0.
REQ-042 Bypass: a retire writes 16'sh7FFF to r4 while ra_addr=4 -> ra_data=16'sh7FFF in the same cycle.
REQ-043 Reset mid-operation: assert reset with two FIFO entries pending -> next cycle alu_ready=1, all registers 0, flag=0, and no late writes occur.
